// File: rtl/dpram_pkg.sv
// Shared definitions for the parameterised dual-port RAM:
// default geometry and the clear-sequencer state encoding.
package dpram_pkg;

    localparam int DEF_WIDTH     = 19;
    localparam int DEF_ADDR_BITS = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/dpram_clear_seq.sv
// Clear sequencer: sweeps zeros through the whole array, one word per
// cycle in ascending order. It starts on reset or on clear_req (IDLE only).
// The counter is one bit wider than the address, so the sweep ends on
// count == depth and never wraps back to 0 in the middle of a sweep.
// state_o exposes the FSM state for observation.
module dpram_clear_seq
    import dpram_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 clk_a,
    input  logic                 reset,
    input  logic                 clear_req,
    output logic                 busy,
    output logic                 clr_we,
    output logic [ADDR_BITS-1:0] clr_addr,
    output logic                 state_o
);

    localparam logic [ADDR_BITS:0] TERM = {1'b1, {ADDR_BITS{1'b0}}};

    clr_state_e           state_q, state_d;
    logic [ADDR_BITS:0]   cnt_q, cnt_d;

    assign clr_addr = cnt_q[ADDR_BITS-1:0];
    assign state_o  = state_q;

    // State and sweep counter; reset always restarts the sweep from address 0.
    always_ff @(posedge clk_a) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and sweep outputs; clear_req is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        clr_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_d == TERM) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/part_param_dpram.sv
// True dual-port RAM with a single clock, synchronous clear sweep,
// write-through read bypass and same-address write collision flag.
// Port A wins a same-address double write. Handshake: a port writes when
// wren_x is high and reads when rden_x is high; no back-pressure, and
// every request is taken on the edge that samples it.
// Optional macro DPRAM_OUTREG_EN adds a second output register stage
// (read latency 2); collision and busy timing are unaffected.
module part_param_dpram
    import dpram_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 clk_a,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] address_a,
    input  logic [ADDR_BITS-1:0] address_b,
    input  logic [WIDTH-1:0]     data_a,
    input  logic [WIDTH-1:0]     data_b,
    input  logic                 wren_a,
    input  logic                 wren_b,
    input  logic                 rden_a,
    input  logic                 rden_b,
    output logic [WIDTH-1:0]     q_a,
    output logic [WIDTH-1:0]     q_b,
    input  logic                 clear_req,
    output logic                 busy,
    output logic                 collision
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic                 clr_we;
    logic [ADDR_BITS-1:0] clr_addr;
    logic                 clr_state;
    logic                 sweeping;
    logic                 same_addr;
    logic [WIDTH-1:0]     word_a, word_b;
    logic [WIDTH-1:0]     q1_a_q, q1_b_q;
    logic                 coll_q;

    dpram_clear_seq #(
        .ADDR_BITS (ADDR_BITS)
    ) u_clear_seq (
        .clk_a     (clk_a),
        .reset     (reset),
        .clear_req (clear_req),
        .busy      (busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .state_o   (clr_state)
    );

    assign sweeping  = (clr_state == CLEAR);
    assign same_addr = (address_a == address_b);
    assign collision = coll_q;

    // Array writes: the sweep owns the array while running; otherwise both
    // ports commit, and port B is dropped on a same-address double write.
    always_ff @(posedge clk_a) begin
        if (!reset) begin
            if (sweeping) begin
                if (clr_we) begin
                    mem_q[clr_addr] <= '0;
                end
            end else begin
                if (wren_a) begin
                    mem_q[address_a] <= data_a;
                end
                if (wren_b && !(wren_a && same_addr)) begin
                    mem_q[address_b] <= data_b;
                end
            end
        end
    end

    // Read words with write-through bypass; port A data is applied last so
    // it wins when both ports write the address being read.
    always_comb begin
        word_a = mem_q[address_a];
        word_b = mem_q[address_b];
        if (wren_b && same_addr) begin
            word_a = data_b;
        end
        if (wren_b) begin
            word_b = data_b;
        end
        if (wren_a) begin
            word_a = data_a;
        end
        if (wren_a && same_addr) begin
            word_b = data_a;
        end
    end

    // First output stage: loads on rden, forced to zero during the sweep.
    always_ff @(posedge clk_a) begin
        if (reset) begin
            q1_a_q <= '0;
            q1_b_q <= '0;
        end else begin
            if (rden_a) begin
                q1_a_q <= sweeping ? '0 : word_a;
            end
            if (rden_b) begin
                q1_b_q <= sweeping ? '0 : word_b;
            end
        end
    end

    // Collision pulse, one cycle after a same-address double write outside a sweep.
    always_ff @(posedge clk_a) begin
        if (reset) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= !sweeping && wren_a && wren_b && same_addr;
        end
    end

`ifdef DPRAM_OUTREG_EN
    logic             rv_a_q, rv_b_q;
    logic [WIDTH-1:0] q2_a_q, q2_b_q;

    // Second output stage; its enable is rden delayed by one cycle.
    always_ff @(posedge clk_a) begin
        if (reset) begin
            rv_a_q <= 1'b0;
            rv_b_q <= 1'b0;
            q2_a_q <= '0;
            q2_b_q <= '0;
        end else begin
            rv_a_q <= rden_a;
            rv_b_q <= rden_b;
            if (rv_a_q) begin
                q2_a_q <= q1_a_q;
            end
            if (rv_b_q) begin
                q2_b_q <= q1_b_q;
            end
        end
    end

    assign q_a = q2_a_q;
    assign q_b = q2_b_q;
`else
    assign q_a = q1_a_q;
    assign q_b = q1_b_q;
`endif

endmodule

// File: tb/tb_part_param_dpram.sv
// Directed bench for part_param_dpram (WIDTH=19, ADDR_BITS=5).
// Works with or without DPRAM_OUTREG_EN; read checks wait the matching latency.
module tb_part_param_dpram;

    localparam int W  = 19;
    localparam int AB = 5;
`ifdef DPRAM_OUTREG_EN
    localparam bit OUTREG = 1'b1;
`else
    localparam bit OUTREG = 1'b0;
`endif

    logic          clk_a = 1'b0;
    logic          reset;
    logic [AB-1:0] address_a, address_b;
    logic [W-1:0]  data_a, data_b;
    logic          wren_a, wren_b, rden_a, rden_b;
    logic [W-1:0]  q_a, q_b;
    logic          clear_req;
    logic          busy;
    logic          collision;

    int vectors = 0;
    int errors  = 0;
    int n;

    part_param_dpram #(.WIDTH(W), .ADDR_BITS(AB)) dut (
        .clk_a     (clk_a),
        .reset     (reset),
        .address_a (address_a),
        .address_b (address_b),
        .data_a    (data_a),
        .data_b    (data_b),
        .wren_a    (wren_a),
        .wren_b    (wren_b),
        .rden_a    (rden_a),
        .rden_b    (rden_b),
        .q_a       (q_a),
        .q_b       (q_b),
        .clear_req (clear_req),
        .busy      (busy),
        .collision (collision)
    );

    // Clock
    always #5 clk_a = ~clk_a;

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk_a);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_a(input logic [AB-1:0] a, input logic [W-1:0] d);
        address_a = a; data_a = d; wren_a = 1'b1;
        tick();
        wren_a = 1'b0;
    endtask

    task automatic rd(input logic [AB-1:0] a, input logic [AB-1:0] b);
        address_a = a; address_b = b; rden_a = 1'b1; rden_b = 1'b1;
        tick();
        rden_a = 1'b0; rden_b = 1'b0;
        if (OUTREG) tick();
    endtask

    // Counts cycles with busy high (bounded); optionally pulses clear_req
    // on the edge after the pulse_at-th busy sample.
    task automatic count_busy(output int cnt, input int pulse_at);
        cnt = 0;
        for (int g = 0; g < 200; g++) begin
            if (!busy) break;
            cnt++;
            clear_req = (cnt == pulse_at);
            tick();
        end
        clear_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clear_req = 1'b0;
        address_a = '0; address_b = '0; data_a = '0; data_b = '0;
        wren_a = 1'b0; wren_b = 1'b0; rden_a = 1'b0; rden_b = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_q_a", q_a, 0);
        check("rst_q_b", q_b, 0);
        check("rst_collision", collision, 0);
        check("rst_busy", busy, 1);

        // Initial sweep length and all-zero contents
        reset = 1'b0;
        count_busy(n, 0);
        check("init_sweep_cycles", n, 32);
        for (int i = 0; i < 32; i += 2) begin
            rd(i[AB-1:0], 5'(i + 1));
            check($sformatf("init_zero_a%0d", i), q_a, 0);
            check($sformatf("init_zero_b%0d", i + 1), q_b, 0);
        end

        // Mixed-port read during write
        address_a = 5'd3; data_a = 19'o1234567; wren_a = 1'b1;
        address_b = 5'd3; rden_b = 1'b1;
        tick();
        wren_a = 1'b0; rden_b = 1'b0;
        if (OUTREG) tick();
        check("rdw_mixed_q_b", q_b, 19'o1234567);

        // Same-address double write: collision pulse, port A wins
        address_a = 5'd7; data_a = 19'o111; wren_a = 1'b1;
        address_b = 5'd7; data_b = 19'o222; wren_b = 1'b1;
        tick();
        wren_a = 1'b0; wren_b = 1'b0;
        check("coll_pulse", collision, 1);
        tick();
        check("coll_clear", collision, 0);
        rd(5'd7, 5'd7);
        check("dbl_wr_a7", q_a, 19'o111);
        check("dbl_wr_b7", q_b, 19'o111);

        // Different addresses in one cycle both commit
        address_a = 5'd10; data_a = 19'h12345; wren_a = 1'b1;
        address_b = 5'd11; data_b = 19'h6789A; wren_b = 1'b1;
        tick();
        wren_a = 1'b0; wren_b = 1'b0;
        check("diff_addr_coll", collision, 0);
        rd(5'd11, 5'd10);
        check("diff_addr_a11", q_a, 19'h6789A);
        check("diff_addr_b10", q_b, 19'h12345);

        // Double write with both ports reading the same address: data_a returned
        address_a = 5'd12; data_a = 19'h5A5A5; wren_a = 1'b1; rden_a = 1'b1;
        address_b = 5'd12; data_b = 19'h3C3C3; wren_b = 1'b1; rden_b = 1'b1;
        tick();
        wren_a = 1'b0; wren_b = 1'b0; rden_a = 1'b0; rden_b = 1'b0;
        check("dbl_rdw_coll", collision, 1);
        if (OUTREG) tick();
        check("dbl_rdw_q_a", q_a, 19'h5A5A5);
        check("dbl_rdw_q_b", q_b, 19'h5A5A5);

        // rden low holds q
        address_b = 5'd10; rden_b = 1'b1;
        tick();
        rden_b = 1'b0;
        if (OUTREG) tick();
        check("hold_q_b_read", q_b, 19'h12345);
        check("hold_q_a", q_a, 19'h5A5A5);

        // Accesses during the sweep: writes dropped, reads give 0, no collision
        rd(5'd7, 5'd7);
        check("pre_sweep_q_a", q_a, 19'o111);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("clear_busy", busy, 1);
        repeat (20) tick();
        address_a = 5'd5; data_a = 19'o66; wren_a = 1'b1; rden_a = 1'b1;
        address_b = 5'd5; data_b = 19'o55; wren_b = 1'b1;
        tick();
        wren_a = 1'b0; wren_b = 1'b0; rden_a = 1'b0;
        check("busy_coll", collision, 0);
        if (OUTREG) tick();
        check("busy_read_q_a", q_a, 0);
        count_busy(n, 0);
        check("busy_done", busy, 0);
        rd(5'd5, 5'd7);
        check("busy_wr_dropped_a5", q_a, 0);
        check("swept_b7", q_b, 0);

        // clear_req while busy is ignored
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        count_busy(n, 6);
        check("clear_req_ignored_cycles", n, 32);

        // Reset mid-sweep restarts from 0
        wr_a(5'd31, 19'o777777);
        rd(5'd31, 5'd31);
        check("pre_rst_a31", q_a, 19'o777777);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (10) tick();
        check("mid_sweep_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_busy(n, 0);
        check("rst_restart_cycles", n, 32);
        rd(5'd31, 5'd3);
        check("rst_sweep_a31", q_a, 0);
        check("rst_sweep_b3", q_b, 0);

        // Read latency
        wr_a(5'd2, 19'o42);
        address_a = 5'd2; rden_a = 1'b1;
        tick();
        rden_a = 1'b0;
        if (OUTREG) begin
            check("latency_stage1_q_a", q_a, 0);
            tick();
        end
        check("latency_q_a", q_a, 19'o42);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/part_param_dpram.md
PART_PARAM_DPRAM -- requirements
Module: part_param_dpram

Interface
REQ-001 Parameter: WIDTH, 19, data word width in bits (1..64).
REQ-002 Parameter: ADDR_BITS, 5, address width; depth = 2**ADDR_BITS words.
REQ-003 Port: clk_a  input  1  single clock for both ports and all state; rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: address_a / address_b  input  ADDR_BITS  port A / B word address.
REQ-006 Port: data_a / data_b  input  WIDTH  port A / B write data.
REQ-007 Port: wren_a / wren_b  input  1  port A / B write enable.
REQ-008 Port: rden_a / rden_b  input  1  port A / B read enable.
REQ-009 Port: q_a / q_b  output  WIDTH  port A / B registered read data.
REQ-010 Port: clear_req  input  1  single-cycle request to zero the whole array.
REQ-011 Port: busy  output  1  high while the clear sweep runs.
REQ-012 Port: collision  output  1  one-cycle pulse: both ports wrote the same address.

Function
REQ-013 True dual port: both ports SHALL read and write in the same cycle.
REQ-014 Writes to different addresses in one cycle SHALL both commit.
REQ-015 Simultaneous writes to the same address: data_a SHALL commit; data_b dropped.
REQ-016 Read latency SHALL be 1 cycle: q_x updates on the edge after rden_x samples high.
REQ-017 rden_x low: q_x SHALL hold its previous value.
REQ-018 Read-during-write (same port or mixed port, same address): q SHALL return the newly written word; with a double write, data_a.
REQ-019 collision SHALL be 1 the cycle after wren_a & wren_b & address_a==address_b, else 0.
REQ-020 Clear FSM states: IDLE, CLEAR. IDLE->CLEAR on clear_req or reset; CLEAR->IDLE after writing the last address.
REQ-021 CLEAR writes zero to one address per cycle, ascending from 0; sweep takes exactly 2**ADDR_BITS cycles; busy=1 in every CLEAR cycle.
REQ-022 While busy: port writes SHALL be dropped; reads with rden high SHALL load q with 0; collision SHALL stay 0.
REQ-023 clear_req while busy SHALL be ignored; the sweep is not restarted.
REQ-024 Clear address counter SHALL be ADDR_BITS+1 wide; terminal condition is count == 2**ADDR_BITS, no wrap to 0 inside a sweep.

Reset
REQ-025 reset SHALL set q_a=0, q_b=0, collision=0, busy=1, clear counter=0, state=CLEAR.
REQ-026 Reset asserted mid-sweep or mid-access SHALL restart the sweep from address 0; array contents after the sweep SHALL be all zero.
REQ-027 Reset has priority over clear_req and port accesses in the same cycle.

Configuration
REQ-028 Macro DPRAM_OUTREG_EN defined: second output register stage on q_a and q_b; read latency 2; stage resets to 0; stage loads every cycle the first stage updated (enable pipelined with rden).
REQ-029 Macro DPRAM_OUTREG_EN undefined: single output register; latency 1 per REQ-016.
REQ-030 collision and busy timing SHALL be identical with and without DPRAM_OUTREG_EN.

Structure
REQ-031 Package dpram_pkg SHALL hold the clear-FSM state enum (IDLE, CLEAR) and the default WIDTH/ADDR_BITS constants.
REQ-032 Clear sequencer SHALL be sub-module dpram_clear_seq (inputs clk_a, reset, clear_req; outputs busy, clr_we, clr_addr); array, bypass and output registers in the top.

Verification (WIDTH=19, ADDR_BITS=5, macro undefined unless noted)
REQ-033 Release reset -> busy high exactly 32 cycles; then read every address -> 0.
REQ-034 wren_a addr 3 data 0o1234567 and rden_b addr 3 same cycle -> q_b=0o1234567 next cycle.
REQ-035 wren_a addr 7 data 0o111, wren_b addr 7 data 0o222 -> collision=1 one cycle; later read addr 7 -> 0o111.
REQ-036 Write addr 31 = 0o777777, clear_req, assert reset at sweep cycle 10 -> busy stays high 32 cycles after reset release; addr 31 reads 0.
REQ-037 During busy, wren_b addr 5 data 0o55 with rden_a addr 5 -> q_a=0; after sweep addr 5 reads 0.
REQ-038 DPRAM_OUTREG_EN defined: write addr 2 = 0o42, read addr 2 -> q_a=0o42 exactly 2 cycles after rden_a.
